// File: rtl/serial_frame_rx_if.sv
// Output word handshake between serial_frame_rx and its consumer.
interface serial_frame_rx_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] DOUT;
  logic              DOUT_PERR;
  logic              DOUT_VALID;
  logic              DOUT_READY;

  modport master (output DOUT, output DOUT_PERR, output DOUT_VALID, input DOUT_READY);
  modport slave  (input DOUT, input DOUT_PERR, input DOUT_VALID, output DOUT_READY);
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start/data(MSB first)/even parity/stop framing into a
// first-word-fall-through FIFO presented over a valid/ready handshake.
module serial_frame_rx #(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             SIN,
  serial_frame_rx_if.master dout_if,
  output logic             FRM_ERR,
  output logic             OVF,
  output logic [CNT_W-1:0] FILL,
  output logic             BUSY
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              perr_q, perr_d;
  logic              frm_err_q, frm_err_d;
  logic              ovf_q, ovf_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W:0]   hold_q, hold_d;
  logic [DATA_W:0]   mem_q [FIFO_DEPTH];
  logic [DATA_W:0]   head;
  logic              push, pop, full, wr_en;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    perr_d    = perr_q;
    frm_err_d = 1'b0;
    push      = 1'b0;
    if (EN) begin
      unique case (state_q)
        S_IDLE: begin
          if (SIN) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          data_d    = {data_q[DATA_W-2:0], SIN};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BW'(DATA_W - 1)) state_d = S_PARITY;
        end
        S_PARITY: begin
          perr_d  = SIN ^ (^data_q);
          state_d = S_STOP;
        end
        S_STOP: begin
          // A high stop bit is a framing error, never a new start bit.
          if (SIN) frm_err_d = 1'b1;
          else     push      = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    head     = mem_q[rd_ptr_q];
    full     = (cnt_q == CNT_W'(FIFO_DEPTH));
    pop      = (cnt_q != '0) && dout_if.DOUT_READY;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    wr_en    = push && (!full || pop);
    ovf_d    = push && full && !pop;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
    hold_d   = pop ? head : hold_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      data_q    <= '0;
      perr_q    <= 1'b0;
      frm_err_q <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
      frm_err_q <= frm_err_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST && wr_en) mem_q[wr_ptr_q] <= {perr_q, data_q};
  end

  assign dout_if.DOUT       = (cnt_q != '0) ? head[DATA_W-1:0] : hold_q[DATA_W-1:0];
  assign dout_if.DOUT_PERR  = (cnt_q != '0) ? head[DATA_W] : hold_q[DATA_W];
  assign dout_if.DOUT_VALID = (cnt_q != '0);
  assign FRM_ERR            = frm_err_q;
  assign OVF                = ovf_q;
  assign FILL               = cnt_q;
  assign BUSY               = (state_q != S_IDLE);
endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: frame-level driver feeds an expected
// word queue; a negedge monitor pops and compares on every handshake.
module tb_serial_frame_rx;
  localparam int DATA_W     = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 3;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             EN  = 1'b0;
  logic             SIN = 1'b0;
  logic             FRM_ERR, OVF, BUSY;
  logic [CNT_W-1:0] FILL;

  serial_frame_rx_if #(.DATA_W(DATA_W)) dif ();

  serial_frame_rx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .SIN(SIN), .dout_if(dif),
    .FRM_ERR(FRM_ERR), .OVF(OVF), .FILL(FILL), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [DATA_W:0]   exp_q [$];
  logic [DATA_W:0]   pend_word, w;
  bit                pend_push, pend_frm, exp_frm, exp_ovf, busy_m, busy_nxt, nf_v, ovf_v;
  int                rdy_mode;
  logic [DATA_W-1:0] d;
  logic              pb, st;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One input cycle; busy_after is the BUSY level expected once this bit is taken.
  task automatic bit_cycle(input bit en, input bit sin, input bit busy_after, input bit is_stop);
    @(posedge CLK);
    #2;
    EN       = en;
    SIN      = sin;
    busy_nxt = busy_after;
    case (rdy_mode)
      0:       dif.DOUT_READY = 1'b0;
      1:       dif.DOUT_READY = 1'b1;
      2:       dif.DOUT_READY = 1'($urandom_range(0, 1));
      default: dif.DOUT_READY = is_stop;
    endcase
  endtask

  task automatic gap(input int mode);
    if (mode == 1) bit_cycle(1'b0, 1'($urandom), 1'b0, 1'b0);
    else if (mode == 2) repeat ($urandom_range(0, 1)) bit_cycle(1'b0, 1'($urandom), 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] dv, input logic pbit, input logic stop, input int gmode);
    bit_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    gap(gmode);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      bit_cycle(1'b1, dv[i], 1'b1, 1'b0);
      gap(gmode);
    end
    bit_cycle(1'b1, pbit, 1'b1, 1'b0);
    gap(gmode);
    bit_cycle(1'b1, stop, 1'b0, 1'b1);
    if (!stop) begin
      pend_push = 1'b1;
      pend_word = {pbit ^ (^dv), dv};
    end else begin
      pend_frm = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) bit_cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    EN  = 1'b0;
    SIN = 1'b0;
    repeat (n) @(posedge CLK);
    #2;
    RST = 1'b1;
    @(negedge CLK);
    chk("dout_rst", 32'(dif.DOUT), 32'd0);
    chk("perr_rst", 32'(dif.DOUT_PERR), 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    rdy_mode = 1;
    while (exp_q.size() != 0 && n < 40) begin
      idle(1);
      n++;
    end
    idle(2);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      exp_q.delete();
      exp_frm   = 1'b0;
      exp_ovf   = 1'b0;
      busy_m    = 1'b0;
      pend_push = 1'b0;
      pend_frm  = 1'b0;
    end else begin
      chk("fill", 32'(FILL), 32'(exp_q.size()));
      chk("valid", 32'(dif.DOUT_VALID), 32'(exp_q.size() != 0));
      chk("frm_err", 32'(FRM_ERR), 32'(exp_frm));
      chk("ovf", 32'(OVF), 32'(exp_ovf));
      chk("busy", 32'(BUSY), 32'(busy_m));
      nf_v  = pend_frm;
      ovf_v = 1'b0;
      if (exp_q.size() != 0 && dif.DOUT_READY) begin
        w = exp_q.pop_front();
        chk("dout", 32'(dif.DOUT), 32'(w[DATA_W-1:0]));
        chk("dout_perr", 32'(dif.DOUT_PERR), 32'(w[DATA_W]));
      end
      if (pend_push) begin
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(pend_word);
        else ovf_v = 1'b1;
      end
      if (EN) busy_m = busy_nxt;
      exp_frm   = nf_v;
      exp_ovf   = ovf_v;
      pend_push = 1'b0;
      pend_frm  = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    dif.DOUT_READY = 1'b0;
    rdy_mode  = 0;
    pend_push = 1'b0;
    pend_frm  = 1'b0;
    busy_nxt  = 1'b0;
    do_reset(3);

    send_frame(4'hA, 1'b0, 1'b0, 0);
    idle(1);
    send_frame(4'h7, 1'b0, 1'b0, 0);
    send_frame(4'h3, 1'b0, 1'b1, 0);
    idle(2);
    drain();

    rdy_mode = 0;
    for (int v = 1; v <= 5; v++) send_frame(4'(v), ^(4'(v)), 1'b0, 0);
    idle(2);
    drain();

    rdy_mode = 0;
    for (int v = 1; v <= 4; v++) send_frame(4'(v), ^(4'(v)), 1'b0, 0);
    rdy_mode = 3;
    send_frame(4'h5, 1'b0, 1'b0, 0);
    drain();

    rdy_mode = 0;
    send_frame(4'hC, 1'b0, 1'b0, 1);
    idle(1);
    drain();

    rdy_mode = 0;
    send_frame(4'h6, 1'b0, 1'b0, 0);
    bit_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    bit_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    bit_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    do_reset(2);
    send_frame(4'hB, 1'b1, 1'b0, 0);
    idle(1);
    drain();

    rdy_mode = 2;
    repeat (60) begin
      d  = DATA_W'($urandom);
      pb = (^d) ^ ($urandom_range(0, 4) == 0);
      st = ($urandom_range(0, 6) == 0);
      send_frame(d, pb, st, ($urandom_range(0, 2) == 0) ? 2 : 0);
      repeat ($urandom_range(0, 2)) bit_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
